// File: rtl/mux_n_to_1_scan_pkg.sv
// Shared definitions for mux_n_to_1_scan: mode encoding and mode helpers.
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // The reserved encoding behaves exactly like HOLD.
    function automatic logic is_hold(input mode_e m);
        return (m == MODE_HOLD) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/mux_n_to_1_scan_if.sv
// Bus bundle between the sampled input banks, the scan mux and its consumer.
// Signal out_par exists only when MUX_PARITY_EN is defined.
interface mux_n_to_1_scan_if #(
    parameter int N = 4,
    parameter int W = 1
);
    localparam int SELW = $clog2(N);

    logic [N*W-1:0]  in_bus;
    logic [SELW-1:0] sel;
    logic [1:0]      mode;
    logic [N-1:0]    ch_en;
    logic [W-1:0]    out;
    logic [SELW-1:0] out_ch;
    logic            out_valid;
    logic            scan_wrap;

`ifdef MUX_PARITY_EN
    logic            out_par;

    modport master (
        output in_bus, sel, mode, ch_en,
        input  out, out_ch, out_valid, scan_wrap, out_par
    );

    modport slave (
        input  in_bus, sel, mode, ch_en,
        output out, out_ch, out_valid, scan_wrap, out_par
    );
`else
    modport master (
        output in_bus, sel, mode, ch_en,
        input  out, out_ch, out_valid, scan_wrap
    );

    modport slave (
        input  in_bus, sel, mode, ch_en,
        output out, out_ch, out_valid, scan_wrap
    );
`endif

endinterface

// File: rtl/mux_n_to_1_scan_next_ch.sv
// Rotate-priority finder: lowest enabled channel strictly above cur, else the
// lowest enabled channel overall (wrapped=1). An out-of-range cur always wraps.
module mux_next_ch #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [SELW-1:0] cur,
    input  logic [N-1:0]    ch_en,
    output logic [SELW-1:0] nxt,
    output logic            any_en,
    output logic            wrapped
);

    logic [SELW-1:0] lo_idx;
    logic [SELW-1:0] hi_idx;
    logic            hi_found;

    // Descending scan so the last hit recorded is the lowest qualifying index.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                lo_idx = SELW'(i);
                if (SELW'(i) > cur) begin
                    hi_idx   = SELW'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign any_en  = |ch_en;
    assign wrapped = any_en && !hi_found;
    assign nxt     = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/mux_n_to_1_scan.sv
// N-channel, W-bit registered mux with manual select, auto-scan sequencer and hold.
// Define MUX_PARITY_EN to add the registered parity output out_par.
module mux_n_to_1_scan
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input logic                clk,
    input logic                rst_n,
    mux_n_to_1_scan_if.slave   bus
);

    localparam int SELW  = $clog2(N);
    localparam int DCNTW = $clog2(DWELL + 1);
    localparam logic [DCNTW-1:0] DWELL_LAST = DCNTW'(DWELL - 1);

    mode_e           mode_in;
    mode_e           mode_q;
    logic [SELW-1:0] cur, cur_d;
    logic [DCNTW-1:0] dwell_cnt, dwell_d;
    logic [W-1:0]    out_q, out_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;
    logic            scan_entry;
    logic            sel_ok;
    logic            sel_en;
    logic            cur_en;
    logic [SELW-1:0] find_from;
    logic [SELW-1:0] entry_ch;
    logic [SELW-1:0] nxt;
    logic            any_en;
    logic            wrapped;

    // Out-of-range indices (possible when N is not a power of two) read as zero.
    function automatic logic [W-1:0] data_at(input logic [N*W-1:0] bus_v,
                                             input logic [SELW-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) r = bus_v[k*W +: W];
        end
        return r;
    endfunction

    function automatic logic en_at(input logic [N-1:0] en_v, input logic [SELW-1:0] idx);
        logic r;
        r = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) r = en_v[k];
        end
        return r;
    endfunction

    assign mode_in    = mode_e'(bus.mode);
    assign scan_entry = (mode_in == MODE_SCAN) && (mode_q != MODE_SCAN);
    assign sel_ok     = int'(bus.sel) < N;
    assign sel_en     = en_at(bus.ch_en, bus.sel);
    assign cur_en     = en_at(bus.ch_en, cur);

    // Entry and advance never coincide, so one finder serves both.
    assign find_from  = scan_entry ? bus.sel : cur;
    assign entry_ch   = sel_en ? bus.sel : nxt;

    mux_next_ch #(
        .N    (N),
        .SELW (SELW)
    ) u_next_ch (
        .cur     (find_from),
        .ch_en   (bus.ch_en),
        .nxt     (nxt),
        .any_en  (any_en),
        .wrapped (wrapped)
    );

    always_comb begin
        cur_d   = cur;
        dwell_d = dwell_cnt;
        out_d   = out_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;

        if (is_hold(mode_in)) begin
            cur_d = cur;
        end else if (mode_in == MODE_MANUAL) begin
            out_d   = data_at(bus.in_bus, bus.sel);
            ch_d    = bus.sel;
            valid_d = sel_ok;
            dwell_d = '0;
        end else if (!any_en) begin
            out_d   = '0;
            valid_d = 1'b0;
            dwell_d = '0;
        end else if (scan_entry) begin
            cur_d   = entry_ch;
            out_d   = data_at(bus.in_bus, entry_ch);
            ch_d    = entry_ch;
            valid_d = 1'b1;
            dwell_d = '0;
        end else if (!valid_q || !cur_en || (dwell_cnt == DWELL_LAST)) begin
            // Resume from idle, current channel disabled, or dwell expired.
            cur_d   = nxt;
            out_d   = data_at(bus.in_bus, nxt);
            ch_d    = nxt;
            valid_d = 1'b1;
            dwell_d = '0;
            wrap_d  = wrapped;
        end else begin
            out_d   = data_at(bus.in_bus, cur);
            ch_d    = cur;
            valid_d = 1'b1;
            dwell_d = dwell_cnt + DCNTW'(1);
        end
    end

`ifdef MUX_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = is_hold(mode_in) ? par_q : (valid_d & (^out_d));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign bus.out_par = par_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= MODE_MANUAL;
            cur       <= '0;
            dwell_cnt <= '0;
            out_q     <= '0;
            ch_q      <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            mode_q    <= mode_in;
            cur       <= cur_d;
            dwell_cnt <= dwell_d;
            out_q     <= out_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
    assign bus.scan_wrap = wrap_q;

endmodule
